// File: rtl/calc_result_tx_if.sv
// Result-capture and byte-stream handshake bundle for calc_result_tx.
// The master modport is the producer/sink side; slave is the streamer.
interface calc_result_tx_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_c;
  logic       in_sign;
  logic       in_zero;
  logic       in_div0;
  logic       in_op;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_last;

  modport master (
    output in_valid, in_c, in_sign, in_zero, in_div0, in_op, tx_ready,
    input  in_ready, tx_valid, tx_data, tx_last
  );

  modport slave (
    input  in_valid, in_c, in_sign, in_zero, in_div0, in_op, tx_ready,
    output in_ready, tx_valid, tx_data, tx_last
  );
endinterface

// File: rtl/calc_result_tx.sv
// Streams one ALU result as a 5-byte ASCII line (op, sign, digit, flag, LF),
// cross-checks the ALU flags against the result and counts completed lines.
module calc_result_tx (
  input  logic              clk,
  input  logic              rst_n,
  calc_result_tx_if.slave   bus,
  output logic [7:0]        frame_cnt,
  output logic              check_err
);

  typedef enum logic [2:0] {IDLE, OP, SIGN, DIGIT, FLAG, EOL} state_t;

  state_t     state, state_nxt;
  logic [3:0] c_q;
  logic       zero_q, div0_q, op_q;
  logic [3:0] mag;
  logic       cap, acc, flag_bad;

  assign cap      = bus.in_valid && bus.in_ready;
  assign acc      = bus.tx_valid && bus.tx_ready;
  assign mag      = c_q[3] ? (~c_q + 4'd1) : c_q;
  assign flag_bad = (bus.in_sign != bus.in_c[3]) || (bus.in_zero != (bus.in_c == 4'b0000));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      c_q       <= 4'd0;
      zero_q    <= 1'b0;
      div0_q    <= 1'b0;
      op_q      <= 1'b0;
      frame_cnt <= 8'd0;
      check_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cap) begin
        c_q    <= bus.in_c;
        zero_q <= bus.in_zero;
        div0_q <= bus.in_div0;
        op_q   <= bus.in_op;
        if (flag_bad) check_err <= 1'b1;
      end
      if (state == EOL && acc) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  // Output bytes decode from the captured registers only, so they hold
  // steady under backpressure and never see the live in_* inputs.
  always_comb begin
    state_nxt    = state;
    bus.in_ready = 1'b0;
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'h00;
    bus.tx_last  = 1'b0;
    case (state)
      IDLE: begin
        bus.tx_valid = 1'b0;
        bus.in_ready = rst_n;
        if (cap) state_nxt = OP;
      end
      OP: begin
        bus.tx_data = op_q ? 8'h53 : 8'h41;
        if (acc) state_nxt = SIGN;
      end
      SIGN: begin
        bus.tx_data = c_q[3] ? 8'h2D : 8'h2B;
        if (acc) state_nxt = DIGIT;
      end
      DIGIT: begin
        bus.tx_data = 8'h30 + {4'h0, mag};
        if (acc) state_nxt = FLAG;
      end
      FLAG: begin
        bus.tx_data = div0_q ? 8'h45 : (zero_q ? 8'h5A : 8'h4E);
        if (acc) state_nxt = EOL;
      end
      EOL: begin
        bus.tx_data = 8'h0A;
        bus.tx_last = 1'b1;
        if (acc) state_nxt = IDLE;
      end
      default: begin
        bus.tx_valid = 1'b0;
        state_nxt    = IDLE;
      end
    endcase
  end

endmodule
